// File: rtl/mul_share_arbiter_if.sv
// Requester, multiplier and response signals of mul_share_arbiter.
// slave is the arbiter side, master the environment side.
interface mul_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic              mul_start;
  logic [W-1:0]      mul_x;
  logic [W-1:0]      mul_y;
  logic              mul_done;
  logic [2*W-1:0]    mul_prod;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_prod;
  logic              rsp_err;
  logic              rsp_ready;
  logic              busy;

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready,
    output mul_start, mul_x, mul_y,
    input  mul_done, mul_prod,
    output rsp_valid, rsp_id, rsp_prod, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready,
    input  mul_start, mul_x, mul_y,
    output mul_done, mul_prod,
    input  rsp_valid, rsp_id, rsp_prod, rsp_err,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one iterative multiplier among NREQ
// requesters, with a done-watchdog and a tagged response.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 32
) (
  input logic                clk,
  input logic                reset,
  mul_share_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [IDW-1:0] last;
  logic [IDW-1:0] win;
  logic           found;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   wx;
  logic [W-1:0]   wy;
  logic           zero_op;
  logic           tmo;

  // Scan downwards so the nearest requester after last wins.
  always_comb begin
    win   = last;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(last) + k) % NREQ]) begin
        win   = IDW'((int'(last) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

  assign wx      = bus.req_x[int'(win)*W +: W];
  assign wy      = bus.req_y[int'(win)*W +: W];
  assign zero_op = (wx == '0) || (wy == '0);
  assign tmo     = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (found) state_n = zero_op ? RESP : ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (bus.mul_done || tmo) state_n = RESP;
      RESP:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found) bus.req_ready[win] = 1'b1;
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last          <= IDW'(NREQ - 1);
      cnt           <= '0;
      bus.mul_start <= 1'b0;
      bus.mul_x     <= '0;
      bus.mul_y     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_prod  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.mul_start <= 1'b0;
      bus.rsp_valid <= (state_n == RESP);
      unique case (state)
        IDLE: begin
          if (found) begin
            last          <= win;
            bus.mul_x     <= wx;
            bus.mul_y     <= wy;
            bus.rsp_id    <= win;
            bus.rsp_prod  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.mul_start <= !zero_op;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // done takes precedence over a coincident timeout
          if (bus.mul_done) begin
            bus.rsp_prod <= bus.mul_prod;
            bus.rsp_err  <= 1'b0;
          end else if (tmo) begin
            bus.rsp_prod <= '0;
            bus.rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
